// File: rtl/seq_divider.sv
// Multicycle restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands with sign fixup.
module seq_divider #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [BITS-1:0] r_quotient;
  logic [BITS-1:0] r_remainder;
  logic            r_dbz_out;

  logic [BITS-1:0] r_rem;
  logic [BITS-1:0] r_quo;
  logic [BITS-1:0] r_dvs;
  logic            r_dbz;

  logic            w_accept;
  logic            w_dvs_zero;
  logic [BITS-1:0] w_dvd_mag;
  logic [BITS-1:0] w_dvs_mag;
  logic [BITS-1:0] w_dvd_load;
  logic [BITS:0]   w_shift;
  logic [BITS:0]   w_diff;
  logic            w_take;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic signed [BITS-1:0] w_dvd_s;
  logic signed [BITS-1:0] w_dvs_s;
  logic                   r_neg_q;
  logic                   r_neg_r;

  function automatic logic [BITS-1:0] negate_if(input logic [BITS-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  assign w_dvd_s   = dividend;
  assign w_dvs_s   = divisor;
  assign w_dvd_mag = (w_dvd_s < 0) ? -w_dvd_s : w_dvd_s;
  assign w_dvs_mag = (w_dvs_s < 0) ? -w_dvs_s : w_dvs_s;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_neg_q <= w_dvd_s[BITS-1] ^ w_dvs_s[BITS-1];
      r_neg_r <= w_dvd_s[BITS-1];
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
`endif

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_dvs_zero = (divisor == '0);
  // On divide-by-zero the quotient register carries the raw dividend to the remainder output.
  assign w_dvd_load = w_dvs_zero ? dividend : w_dvd_mag;

  assign w_shift = {r_rem, r_quo[BITS-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_take  = ~w_diff[BITS];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_dvs_zero ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem <= '0;
      r_quo <= w_dvd_load;
      r_dvs <= w_dvs_mag;
      r_dbz <= w_dvs_zero;
    end else if (r_state == S_CALC) begin
      r_rem <= w_take ? w_diff[BITS-1:0] : w_shift[BITS-1:0];
      r_quo <= {r_quo[BITS-2:0], w_take};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz_out   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (r_state == S_DONE);
      if (w_accept) begin
        r_cnt       <= CW'(BITS);
        r_quotient  <= '0;
        r_remainder <= '0;
        r_dbz_out   <= 1'b0;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt - CW'(1);
      end else if (r_state == S_DONE) begin
        if (r_dbz) begin
          r_quotient  <= '1;
          r_remainder <= r_quo;
          r_dbz_out   <= 1'b1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          r_quotient  <= negate_if(r_quo, r_neg_q);
          r_remainder <= negate_if(r_rem, r_neg_r);
`else
          r_quotient  <= r_quo;
          r_remainder <= r_rem;
`endif
          r_dbz_out   <= 1'b0;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz_out;

endmodule
